ram_arbiter: RTL and testbench

Shares the single DMA/RAM port among several requesters (file handler, decompress handler, CNN engine, host path) with a req/gnt/done handshake and round-robin fairness. It sits between the requesters and `DMA`, and replaces the static load/cnn/writeSignal selector muxes. Only one RAM transaction is in flight at a time; each transaction runs to completion before the next grant.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_picker.sv | 31 +++
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and FSM encoding for the RAM port arbiter.
// Used by rr_picker and ram_arbiter.
package ram_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin selector: the first active request
// after lastIdx (wrapping) wins.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = idxWidth(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] lastIdx,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    int cand;

    // Scan from farthest to nearest so the nearest active request wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(lastIdx) + k) % NREQ;
            if (req[IDX_W'(cand)]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one DMA/RAM port between requesters.
// Optional WAIT watchdog compiled in with ARB_WATCHDOG_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_read,
    output logic                     ram_write,
    input  logic [DATA_W-1:0]        ram_rdata,
    input  logic                     ram_done_read,
    input  logic                     ram_done_write,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W = idxWidth(NREQ);

    state_t             state;
    logic [IDX_W-1:0]   curIdx;
    logic [IDX_W-1:0]   lastIdx;
    logic [IDX_W-1:0]   winner;
    logic               curWe;
    logic               pickValid;
    logic               hit;
    logic               wdFire;
    logic [ADDR_W-1:0]  addrArr  [NREQ];
    logic [DATA_W-1:0]  wdataArr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : gUnpack
        assign addrArr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdataArr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) uPicker (
        .req     (req),
        .lastIdx (lastIdx),
        .valid   (pickValid),
        .winner  (winner)
    );

    // Only the completion type matching the latched direction counts.
    assign hit  = curWe ? ram_done_write : ram_done_read;
    assign busy = (state != IDLE);

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = idxWidth(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wdCnt;

    assign wdFire = (state == WAIT) && !hit &&
                    (wdCnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wdCnt       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wdFire;
            if (state != WAIT) begin
                wdCnt <= '0;
            end else begin
                wdCnt <= wdCnt + 1'b1;
            end
        end
    end
`else
    assign wdFire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            curIdx    <= '0;
            curWe     <= 1'b0;
            lastIdx   <= IDX_W'(NREQ - 1);
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
        end else begin
            done      <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        curIdx    <= winner;
                        curWe     <= req_we[winner];
                        ram_addr  <= addrArr[winner];
                        ram_wdata <= wdataArr[winner];
                        gnt       <= NREQ'(1) << winner;
                        ram_read  <= !req_we[winner];
                        ram_write <= req_we[winner];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (hit || wdFire) begin
                        // An aborted read returns zero rather than bus noise.
                        if (!curWe) begin
                            rdata <= hit ? ram_rdata : '0;
                        end
                        done    <= gnt;
                        gnt     <= '0;
                        lastIdx <= curIdx;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter with a
// transaction-level round-robin reference model.
module tb_ram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;
`ifdef ARB_WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] reqV = '0;
    logic [NREQ-1:0] weV  = '0;
    logic [AW-1:0]   addrA  [NREQ];
    logic [DW-1:0]   wdataA [NREQ];
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ*DW-1:0] reqWdata;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ramAddr;
    logic [DW-1:0]   ramWdata;
    logic            ramRead;
    logic            ramWrite;
    logic [DW-1:0]   ramRdata = '0;
    logic            ramDoneRead = 1'b0;
    logic            ramDoneWrite = 1'b0;
    logic            busy;
    logic            timeoutErr;

    int              nChecks = 0;
    int              nPass = 0;
    int              mLast;
    logic [DW-1:0]   mRdata;
    bit              live = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        reqAddr  = '0;
        reqWdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqAddr[i*AW +: AW]  = addrA[i];
            reqWdata[i*DW +: DW] = wdataA[i];
        end
    end

    ram_arbiter #(
        .NREQ        (NREQ),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .RST            (rst),
        .req            (reqV),
        .req_we         (weV),
        .req_addr       (reqAddr),
        .req_wdata      (reqWdata),
        .gnt            (gnt),
        .done           (done),
        .rdata          (rdata),
        .ram_addr       (ramAddr),
        .ram_wdata      (ramWdata),
        .ram_read       (ramRead),
        .ram_write      (ramWrite),
        .ram_rdata      (ramRdata),
        .ram_done_read  (ramDoneRead),
        .ram_done_write (ramDoneWrite),
        .busy           (busy),
        .timeout_err    (timeoutErr)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference round-robin: first request after the last winner.
    function automatic int rrModel(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (live) begin
            chk("oneHot", 64'($countones(gnt) <= 1), 1);
            chk("busyGnt", busy, gnt != '0);
`ifndef ARB_WATCHDOG_EN
            chk("toErrTied", timeoutErr, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "Gnt"}, gnt, 0);
        chk({tag, "Done"}, done, 0);
        chk({tag, "Rdata"}, rdata, 0);
        chk({tag, "Addr"}, ramAddr, 0);
        chk({tag, "Wdata"}, ramWdata, 0);
        chk({tag, "Strobe"}, {ramRead, ramWrite}, 0);
        chk({tag, "Busy"}, busy, 0);
        chk({tag, "ToErr"}, timeoutErr, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        chkZero("rst");
        tick();
        rst = 1'b0;
        mLast = NREQ - 1;
        mRdata = '0;
        ramDoneRead = 1'b0;
        ramDoneWrite = 1'b0;
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            addrA[i]  = AW'($urandom);
            wdataA[i] = DW'($urandom);
        end
    endtask

    // Entered in an IDLE cycle with reqV already driven.
    task automatic runTxn(input int nWait, input bit spur, input bit drop,
                          input bit issueNoise, input logic [DW-1:0] rd,
                          output int granted);
        int w;
        bit we;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        granted = -1;
        w = rrModel(reqV, mLast);
        if (w < 0) return;
        we = weV[w];
        ea = addrA[w];
        ew = wdataA[w];
        tick();
        granted = oneHotIdx(gnt);
        chk("gnt", gnt, 1 << w);
        chk("ramRead", ramRead, !we);
        chk("ramWrite", ramWrite, we);
        chk("ramAddr", ramAddr, ea);
        if (we) chk("ramWdata", ramWdata, ew);
        chk("doneIssue", done, 0);
        scramble();
        if (drop) reqV[w] = 1'b0;
        if (issueNoise) begin
            if (we) ramDoneWrite = 1'b1;
            else ramDoneRead = 1'b1;
        end
        tick();
        ramDoneRead = 1'b0;
        ramDoneWrite = 1'b0;
        chk("strobeOnce", {ramRead, ramWrite}, 0);
        chk("addrHold", ramAddr, ea);
        if (we) chk("wdataHold", ramWdata, ew);
        chk("gntHold", gnt, 1 << w);
        for (int c = 1; c < nWait; c++) begin
            if (spur) begin
                if (we) ramDoneRead = 1'b1;
                else ramDoneWrite = 1'b1;
            end
            ramRdata = DW'($urandom);
            tick();
            ramDoneRead = 1'b0;
            ramDoneWrite = 1'b0;
            chk("waitDone", done, 0);
            chk("waitGnt", gnt, 1 << w);
        end
        ramRdata = rd;
        if (we) ramDoneWrite = 1'b1;
        else ramDoneRead = 1'b1;
        tick();
        ramDoneRead = 1'b0;
        ramDoneWrite = 1'b0;
        ramRdata = DW'($urandom);
        if (!we) mRdata = rd;
        mLast = w;
        chk("done", done, 1 << w);
        chk("gntClr", gnt, 0);
        chk("busyClr", busy, 0);
        chk("rdata", rdata, mRdata);
    endtask

    initial begin
        int g;
        int expOrder [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            addrA[i]  = '0;
            wdataA[i] = '0;
        end
        tick();
        doReset();
        live = 1'b1;

        // Completions while idle must be ignored.
        ramDoneRead = 1'b1;
        ramDoneWrite = 1'b1;
        tick();
        ramDoneRead = 1'b0;
        ramDoneWrite = 1'b0;
        chk("idleDone", done, 0);
        chk("idleGnt", gnt, 0);

        // Single read from requester 2.
        reqV = 4'b0100;
        weV  = 4'b0000;
        addrA[2] = 16'h0040;
        runTxn(3, 1'b0, 1'b0, 1'b0, 16'hBEEF, g);
        chk("singleRdata", rdata, 16'hBEEF);
        reqV = '0;
        tick();

`ifdef ARB_WATCHDOG_EN
        // DMA never completes: watchdog aborts after TO WAIT cycles.
        reqV = 4'b0001;
        weV  = 4'b0000;
        tick();
        chk("wdGnt", gnt, 1);
        reqV = '0;
        tick();
        for (int c = 1; c < TO; c++) begin
            tick();
            chk("wdWaitDone", done, 0);
            chk("wdWaitTo", timeoutErr, 0);
        end
        tick();
        chk("wdDone", done, 1);
        chk("wdTo", timeoutErr, 1);
        chk("wdRdata", rdata, 0);
        chk("wdIdle", busy, 0);
        mRdata = '0;
        mLast = 0;
        tick();
        chk("wdToOnce", timeoutErr, 0);
`endif

        // Full contention, round-robin order from reset.
        doReset();
        reqV = 4'b1111;
        weV  = 4'b0101;
        scramble();
        for (int i = 0; i < 5; i++) begin
            runTxn(2, 1'b0, 1'b0, 1'b0, DW'($urandom), g);
            chk("rrOrder", g, expOrder[i]);
        end
        reqV = '0;
        tick();

        // Write with a spurious read completion in WAIT.
        reqV = 4'b0010;
        weV  = 4'b0010;
        addrA[1]  = 16'h0010;
        wdataA[1] = 16'h1234;
        runTxn(3, 1'b1, 1'b0, 1'b1, 16'h5A5A, g);
        reqV = '0;
        tick();

        // Requester drops req mid-transaction.
        reqV = 4'b0001;
        weV  = 4'b0000;
        runTxn(2, 1'b0, 1'b1, 1'b0, 16'hC0DE, g);
        tick();

        // Reset while requester 3 holds the port.
        doReset();
        reqV = 4'b1000;
        weV  = 4'b0000;
        tick();
        chk("preRstGnt", gnt, 4'b1000);
        tick();
        rst = 1'b1;
        #1;
        chkZero("midRst");
        tick();
        chk("midRstDone", done, 0);
        rst = 1'b0;
        mLast = NREQ - 1;
        mRdata = '0;
        reqV = 4'b1001;
        runTxn(2, 1'b0, 1'b0, 1'b0, DW'($urandom), g);
        chk("postRstWinner", g, 0);
        reqV = '0;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                reqV = '0;
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    chk("gapGnt", gnt, 0);
                    chk("gapRdata", rdata, mRdata);
                end
            end
            reqV = NREQ'($urandom_range(1, 15));
            weV  = NREQ'($urandom);
            scramble();
            runTxn(int'($urandom_range(1, 4)), 1'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   DW'($urandom), g);
        end
        reqV = '0;
        tick();
        tick();
        live = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
